// File: rtl/dshot_encoder.sv
// DShot transmitter: latches {throttle, telemetry} plus a 4-bit CRC into a 16-bit
// frame and drives it MSB-first as pulse-width-coded bits on a registered pin.
module dshot_encoder #(
  parameter int BIT_CYCLES = 107,
  parameter int T1H_CYCLES = 80,
  parameter int T0H_CYCLES = 40,
  parameter int GAP_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] throttle,
  input  logic        telemetry,
  output logic        dshot_out,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    shift_q, shift_d;
  logic [3:0]     bit_q, bit_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           out_d;
  logic           done_d;

  logic [11:0]    payload;
  logic [3:0]     crc;
  logic [15:0]    frame_word;

  assign payload    = {throttle, telemetry};
  assign crc        = payload[3:0] ^ payload[7:4] ^ payload[11:8];
  assign frame_word = {payload, crc};

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SEND;
          shift_d = frame_word;
          bit_d   = '0;
          cyc_d   = '0;
        end
      end
      SEND: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {shift_q[14:0], 1'b0};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            state_d = GAP;
            gap_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is computed from next-cycle state so the pin flop leads by zero cycles.
    out_d = (state_d == SEND) && (cyc_d < (shift_d[15] ? T1H : T0H));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      cyc_q      <= '0;
      gap_q      <= '0;
      dshot_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      cyc_q      <= cyc_d;
      gap_q      <= gap_d;
      dshot_out  <= out_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_dshot_encoder.sv
// Bench for dshot_encoder: per-cycle timing model plus a pulse-width decoding scoreboard.
module tb_dshot_encoder;

  localparam int BITC     = 107;
  localparam int T1H      = 80;
  localparam int T0H      = 40;
  localparam int GAPC     = 32;
  localparam int SEND_LEN = 16 * BITC;
  localparam int PERIOD   = 1 + SEND_LEN + GAPC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [10:0] throttle = '0;
  logic        telemetry = 1'b0;
  logic        in_ready, dshot_out, busy, frame_done;

  dshot_encoder #(
    .BIT_CYCLES(BITC),
    .T1H_CYCLES(T1H),
    .T0H_CYCLES(T0H),
    .GAP_CYCLES(GAPC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .throttle  (throttle),
    .telemetry (telemetry),
    .dshot_out (dshot_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_frame(input logic [10:0] thr, input logic tel);
    int v, c;
    v = int'(thr) * 2 + int'(tel);
    c = (v ^ (v >> 4) ^ (v >> 8)) & 15;
    return 16'(v * 16 + c);
  endfunction

  // Reference model state
  bit          armed = 0;
  bit          active = 0;
  longint      acc_a = 0;
  logic [15:0] acc_f = '0;
  int          acc_count = 0;
  longint      acc_hist[$];

  // Scoreboard state
  logic [15:0] exp_q[$];
  logic        prev_out = 1'b0;
  longint      rise_c = 0;
  int          nbits = 0;
  logic [15:0] word = '0;
  logic [15:0] last_word = '0;
  int          dec_count = 0;
  int          aborted = 0;

  longint      rel, w;
  int          k, ph;
  logic        e_out, e_done, e_busy, eb;
  logic [15:0] tmp;

  always @(negedge clk) begin
    rel    = cyc - acc_a;
    e_busy = active && rel >= 1 && rel <= PERIOD - 1;
    e_done = active && rel == SEND_LEN + 1;
    e_out  = 1'b0;
    if (active && rel >= 1 && rel <= SEND_LEN) begin
      k     = int'((rel - 1) / BITC);
      ph    = int'((rel - 1) % BITC);
      e_out = (ph < (acc_f[15-k] ? T1H : T0H));
    end
    if (armed) begin
      check("dshot_out", dshot_out, e_out);
      check("frame_done", frame_done, e_done);
      check("in_ready", in_ready, !e_busy);
      check("busy", busy, e_busy);
      if (dshot_out && !prev_out) begin
        rise_c = cyc;
      end else if (!dshot_out && prev_out) begin
        w = cyc - rise_c;
        if (exp_q.size() == 0) begin
          check("orphan_pulse", 1, 0);
        end else begin
          eb = exp_q[0][15-nbits];
          check("pulse_width", w, eb ? T1H : T0H);
          word = {word[14:0], (w > 60)};
          nbits++;
          if (nbits == 16) begin
            check("frame", word, exp_q[0]);
            tmp = ref_frame(word[15:5], word[4]);
            check("crc", word[3:0], tmp[3:0]);
            last_word = word;
            dec_count++;
            void'(exp_q.pop_front());
            nbits = 0;
          end
        end
      end
      prev_out = dshot_out;
    end
    if (rst) begin
      if (armed && exp_q.size() > 0) begin
        exp_q.delete();
        aborted++;
      end
      nbits    = 0;
      active   = 0;
      armed    = 1;
      prev_out = 1'b0;
    end else if (armed && in_valid && !e_busy) begin
      active = 1;
      acc_a  = cyc;
      acc_f  = ref_frame(throttle, telemetry);
      exp_q.push_back(acc_f);
      acc_hist.push_back(cyc);
      acc_count++;
    end
  end

  task automatic send(input logic [10:0] thr, input logic tel);
    int n0;
    n0        = acc_count;
    throttle  = thr;
    telemetry = tel;
    in_valid  = 1'b1;
    for (int i = 0; i < 4000 && acc_count == n0; i++) @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc_count == n0) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_decoded(input int target);
    for (int i = 0; i < 2500 && dec_count < target; i++) @(posedge clk);
    #1;
    if (dec_count < target) check("decode_timeout", dec_count, target);
  endtask

  task automatic directed(input logic [10:0] thr, input logic tel,
                          input logic [15:0] golden, input string tag);
    int d0;
    d0 = dec_count;
    send(thr, tel);
    wait_decoded(d0 + 1);
    check(tag, last_word, golden);
  endtask

  initial begin
    #(1500000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, n0, d0;
    // Reset with a pending request: reset must win over the accept.
    in_valid = 1'b1;
    throttle = 11'd1046;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("reset_ready", in_ready, 1);
    check("reset_line", dshot_out, 0);
    repeat (500) @(posedge clk);
    #1;

    directed(11'd1046, 1'b0, 16'h82C6, "frame_1046");
    directed(11'd0,    1'b0, 16'h0000, "frame_0");
    directed(11'd2047, 1'b1, 16'hFFFF, "frame_2047");
    directed(11'd48,   1'b1, 16'h0617, "frame_48");

    // Back-to-back with inputs scrambled every cycle.
    h0 = acc_hist.size();
    n0 = acc_count;
    in_valid = 1'b1;
    for (int i = 0; i < 6000 && acc_count < n0 + 3; i++) begin
      @(posedge clk);
      #1;
      throttle  = 11'($urandom);
      telemetry = 1'($urandom);
    end
    in_valid = 1'b0;
    if (acc_hist.size() >= h0 + 3) begin
      check("accept_spacing", acc_hist[h0+1] - acc_hist[h0], PERIOD);
      check("accept_spacing", acc_hist[h0+2] - acc_hist[h0+1], PERIOD);
    end else begin
      check("b2b_accepts", acc_hist.size() - h0, 3);
    end
    wait_decoded(dec_count + 1);

    // Reset during a high phase of bit 7, then a clean frame.
    send(11'd2047, 1'b1);
    repeat (759) @(posedge clk);
    #1;
    check("pre_reset_high", dshot_out, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_line_low", dshot_out, 0);
    check("reset_ready_mid", in_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    directed(11'd1046, 1'b0, 16'h82C6, "frame_after_reset");

    for (int n = 0; n < 24; n++) begin
      d0 = int'($urandom_range(0, 5));
      repeat (d0) begin
        @(posedge clk);
        #1;
      end
      send(11'($urandom), 1'($urandom));
    end
    repeat (PERIOD + 10) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("frame_count", dec_count + aborted, acc_count);
    check("aborted_count", aborted, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
